seq_multiplier_nxn: RTL and testbench
=====================================

# seq_multiplier_nxn

Parametrised sequential shift-add multiplier, the generalised successor to the fixed 8x8 multiplier core. It takes two WIDTH-bit operands on a start pulse and produces a 2*WIDTH-bit product after a fixed latency, signalled by a one-cycle done pulse. It adds a runtime signed/unsigned mode and a busy indication. It sits under the top-level wrapper, which owns the seven-segment display logic.

## Interface
- WIDTH, 8, operand width in bits; legal range 2..32
- clk  in  1  system clock; all state changes on rising edge
- reset_a  in  1  asynchronous, active-high reset
- start  in  1  request; sampled on rising edge; accepted only when not busy
- signed_mode  in  1  sampled with start; 1 = two's-complement operands and product, 0 = unsigned
- dataa  in  WIDTH  multiplicand; sampled with accepted start
- datab  in  WIDTH  multiplier; sampled with accepted start
- busy  out  1  high while a multiplication is in progress (CALC and FIX)
- done_flag  out  1  one-cycle pulse; product valid from this cycle on
- product  out  2*WIDTH  result; held until the next accepted start

## Operation
- States: IDLE, CALC, FIX, DONE.
- IDLE or DONE with start=1 captures the operands, clears the accumulator and bit counter, then goes to CALC.
  - Unsigned mode: the operands are used as given.
  - Signed mode: the magnitudes |dataa| and |datab| are stored as WIDTH-bit unsigned values, and neg = sign(a) XOR sign(b) is stored.
  - -2^(WIDTH-1) has magnitude 2^(WIDTH-1), which fits WIDTH bits unsigned; no special case.
- CALC lasts exactly WIDTH cycles, one multiplier bit per cycle, LSB first.
  - If the bit is 1, add the multiplicand shifted left by the bit index to the 2*WIDTH-bit accumulator.
  - The accumulator never overflows: the unsigned product is at most (2^WIDTH-1)^2.
  - After bit WIDTH-1, go to FIX.
- FIX lasts one cycle. If signed_mode and neg, product <= two's complement of the accumulator; otherwise product <= accumulator. Then go to DONE.
- DONE lasts one cycle with done_flag=1, then returns to IDLE. product is unchanged.
- start while busy (CALC/FIX) is ignored, with no queueing. Operand or mode changes during busy have no effect.
- start in the DONE cycle is accepted, giving back-to-back operations.
- A zero operand still takes the full latency; there is no early exit.
- Reset values on reset_a: state IDLE, busy=0, done_flag=0, product=0, accumulator, counter and neg = 0.
- reset_a asserted mid-operation aborts immediately: no done pulse, product=0.

## Timing
- start sampled high at edge T (state IDLE/DONE):
  - busy=1 from T through T+WIDTH+1.
  - product updates at edge T+WIDTH+1.
  - done_flag=1 for the cycle after edge T+WIDTH+1, cleared at T+WIDTH+2.
- Latency from start edge to done is WIDTH+1 cycles; WIDTH=8 gives 9 cycles.
- Throughput: one result every WIDTH+2 cycles with start held or re-pulsed in DONE.
- All outputs are registered; no combinational path from inputs to outputs.
- Asynchronous reset assert takes effect without a clock edge. Deassert is assumed synchronised externally.

## Structure
- Package mult_pkg:
  - the state enum (IDLE, CALC, FIX, DONE) with explicit 2-bit encoding;
  - the localparam rule for counter width, $clog2(WIDTH).
- No sub-module; a single always_ff FSM/datapath plus a small combinational magnitude/negate function.
- The seven-segment decoder remains a separate block in the wrapper and is not part of this block.

## Test plan
- WIDTH=8, unsigned, 10 x 5 -> done_flag after 9 cycles, product=50 (0x0032), busy low afterwards.
- WIDTH=8, signed, -3 (0xFD) x 7 -> product=0xFFEB (-21); 7 x 3 unsigned then -> 21.
- WIDTH=8, signed, 0x80 x 0x80 -> 0x4000; unsigned 255 x 255 -> 0xFE01.
- start pulsed again at cycle 3 of CALC with different operands -> ignored; original result delivered at its normal time, exactly one done pulse.
- reset_a asserted at cycle 4 of CALC -> immediate busy=0, product=0, no done; a following start of 7 x 3 -> 21 after 9 cycles.
- WIDTH=4 instance, unsigned 15 x 15 -> product=225 (0xE1) after 5 cycles; back-to-back start held high in DONE -> second result 6 cycles after the first.

Source files
------------

// File: rtl/mult_pkg.sv
// Shared definitions for the sequential shift-add multiplier: FSM encoding and
// the rule that sizes the bit counter from the operand width.
package mult_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CALC = 2'b01,
        FIX  = 2'b10,
        DONE = 2'b11
    } mult_state_t;

    // A single-bit counter still covers WIDTH=2 (loaded with 1, counts to 0).
    function automatic int cnt_width(input int width);
        return (width > 1) ? $clog2(width) : 1;
    endfunction

endpackage

// File: rtl/seq_multiplier_nxn.sv
// Parametrised shift-add multiplier, one multiplier bit per clock, with a
// runtime signed/unsigned mode handled as magnitude multiply plus final negate.
//
// state | meaning
// IDLE  | waiting for start
// CALC  | WIDTH cycles, one multiplier bit consumed per cycle, LSB first
// FIX   | apply result sign, load product
// DONE  | done_flag high for one cycle; a new start is accepted here
module seq_multiplier_nxn
    import mult_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 reset_a,
    input  logic                 start,
    input  logic                 signed_mode,
    input  logic [WIDTH-1:0]     dataa,
    input  logic [WIDTH-1:0]     datab,
    output logic                 busy,
    output logic                 done_flag,
    output logic [2*WIDTH-1:0]   product
);

    localparam int CW = cnt_width(WIDTH);

    mult_state_t           state;
    logic [2*WIDTH-1:0]    mcand;
    logic [WIDTH-1:0]      mplier;
    logic [2*WIDTH-1:0]    acc;
    logic [CW-1:0]         cnt;
    logic                  neg;

    // The most negative value maps to 2^(WIDTH-1), which still fits unsigned.
    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v,
                                                   input logic is_signed);
        return (is_signed && v[WIDTH-1]) ? -v : v;
    endfunction

    always_ff @(posedge clk or posedge reset_a) begin
        if (reset_a) begin
            state     <= IDLE;
            mcand     <= '0;
            mplier    <= '0;
            acc       <= '0;
            cnt       <= '0;
            neg       <= 1'b0;
            busy      <= 1'b0;
            done_flag <= 1'b0;
            product   <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    done_flag <= 1'b0;
                    if (start) begin
                        mcand  <= {{WIDTH{1'b0}}, magnitude(dataa, signed_mode)};
                        mplier <= magnitude(datab, signed_mode);
                        neg    <= signed_mode & (dataa[WIDTH-1] ^ datab[WIDTH-1]);
                        acc    <= '0;
                        cnt    <= CW'(WIDTH - 1);
                        busy   <= 1'b1;
                        state  <= CALC;
                    end else begin
                        state  <= IDLE;
                    end
                end
                CALC: begin
                    // Multiplicand shifts left as the multiplier shifts right, so
                    // bit i always adds a << i without an index mux.
                    if (mplier[0]) begin
                        acc <= acc + mcand;
                    end
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    if (cnt == '0) begin
                        state <= FIX;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                FIX: begin
                    product   <= neg ? -acc : acc;
                    busy      <= 1'b0;
                    done_flag <= 1'b1;
                    state     <= DONE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_multiplier_nxn.sv
// Self-checking bench: timeline model of the WIDTH=8 instance checked every
// cycle, plus directed literal checks on WIDTH=8 and WIDTH=4 instances.
module tb_seq_multiplier_nxn;

    logic        clk;
    logic        reset_a;
    logic        start, signed_mode;
    logic [7:0]  dataa, datab;
    logic        busy, done_flag;
    logic [15:0] product;

    logic        start4, mode4;
    logic [3:0]  a4, b4;
    logic        busy4, done4;
    logic [7:0]  product4;

    int errors = 0;
    int checks = 0;
    logic en_cmp = 1'b0;

    seq_multiplier_nxn #(.WIDTH(8)) dut8 (
        .clk(clk), .reset_a(reset_a), .start(start), .signed_mode(signed_mode),
        .dataa(dataa), .datab(datab), .busy(busy), .done_flag(done_flag),
        .product(product));

    seq_multiplier_nxn #(.WIDTH(4)) dut4 (
        .clk(clk), .reset_a(reset_a), .start(start4), .signed_mode(mode4),
        .dataa(a4), .datab(b4), .busy(busy4), .done_flag(done4),
        .product(product4));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: an accepted operation finishes WIDTH+1 edges after its start edge.
    logic        m_busy = 1'b0, m_done = 1'b0, pending = 1'b0;
    logic [15:0] m_prod = '0, m_res = '0;
    int          cyc = 0, t_done = 0;

    initial begin
        logic   old_busy;
        longint sa, sb;
        forever begin
            @(posedge clk or posedge reset_a);
            if (reset_a) begin
                m_busy = 0; m_done = 0; pending = 0; m_prod = '0;
            end else begin
                cyc++;
                old_busy = m_busy;
                m_done = 0;
                if (pending && cyc == t_done) begin
                    m_prod = m_res; m_done = 1; pending = 0;
                end
                if (start && !old_busy) begin
                    sa = signed_mode ? longint'($signed(dataa)) : longint'(dataa);
                    sb = signed_mode ? longint'($signed(datab)) : longint'(datab);
                    m_res = 16'(sa * sb);
                    pending = 1;
                    t_done = cyc + 9;
                end
                m_busy = pending;
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (en_cmp) begin
                check("cmp_busy", 32'(busy), 32'(m_busy));
                check("cmp_done", 32'(done_flag), 32'(m_done));
                check("cmp_product", 32'(product), 32'(m_prod));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic mode,
                          input logic [15:0] exp);
        int n;
        start = 1; dataa = a; datab = b; signed_mode = mode;
        tick();
        start = 0;
        n = 0;
        while (!done_flag && n < 30) begin
            tick();
            n++;
        end
        check("op_latency", 32'(n), 32'd9);
        check("op_product", 32'(product), 32'(exp));
        check("model_pin", 32'(m_prod), 32'(exp));
        tick();
        check("op_busy_after", 32'(busy), 32'd0);
    endtask

    task automatic run4(input logic [3:0] a, input logic [3:0] b, input logic mode,
                        input logic [7:0] exp);
        int n;
        start4 = 1; a4 = a; b4 = b; mode4 = mode;
        tick();
        start4 = 0;
        n = 0;
        while (!done4 && n < 30) begin
            tick();
            n++;
        end
        check("w4_latency", 32'(n), 32'd5);
        check("w4_product", 32'(product4), 32'(exp));
        tick();
    endtask

    initial begin
        int n, dones;
        reset_a = 1; start = 0; signed_mode = 0; dataa = '0; datab = '0;
        start4 = 0; mode4 = 0; a4 = '0; b4 = '0;
        repeat (2) tick();
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done_flag), 32'd0);
        check("rst_product", 32'(product), 32'd0);
        check("rst_product4", 32'(product4), 32'd0);
        reset_a = 0;
        en_cmp = 1;
        tick();

        run_op(8'd10, 8'd5, 1'b0, 16'h0032);
        run_op(8'hFD, 8'd7, 1'b1, 16'hFFEB);
        run_op(8'd7, 8'd3, 1'b0, 16'd21);
        run_op(8'h80, 8'h80, 1'b1, 16'h4000);
        run_op(8'd255, 8'd255, 1'b0, 16'hFE01);
        run_op(8'h80, 8'h01, 1'b1, 16'hFF80);
        run_op(8'd0, 8'd5, 1'b0, 16'h0000);
        run_op(8'hFF, 8'hFF, 1'b1, 16'h0001);

        // Restart during CALC must be ignored.
        start = 1; dataa = 8'd10; datab = 8'd5; signed_mode = 0;
        tick();
        start = 0;
        repeat (3) tick();
        start = 1; dataa = 8'd3; datab = 8'd3;
        tick();
        start = 0;
        dones = 0;
        n = 4;
        for (int i = 0; i < 12; i++) begin
            if (done_flag) begin
                dones++;
                if (dones == 1) check("ign_latency", 32'(n), 32'd9);
            end
            tick();
            n++;
        end
        check("ign_done_count", 32'(dones), 32'd1);
        check("ign_product", 32'(product), 32'h0032);

        // Asynchronous reset mid-CALC aborts with no done pulse.
        start = 1; dataa = 8'd100; datab = 8'd2;
        tick();
        start = 0;
        repeat (4) tick();
        reset_a = 1;
        #1;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_product", 32'(product), 32'd0);
        tick();
        reset_a = 0;
        dones = 0;
        for (int i = 0; i < 12; i++) begin
            if (done_flag) dones++;
            tick();
        end
        check("abort_no_done", 32'(dones), 32'd0);
        run_op(8'd7, 8'd3, 1'b0, 16'd21);

        // WIDTH=4: latency 5, then back-to-back with start held through DONE.
        start4 = 1; a4 = 4'd15; b4 = 4'd15; mode4 = 0;
        tick();
        a4 = 4'd3; b4 = 4'd5;
        n = 0;
        while (!done4 && n < 30) begin
            tick();
            n++;
        end
        check("w4_first_latency", 32'(n), 32'd5);
        check("w4_first_product", 32'(product4), 32'hE1);
        n = 0;
        tick();
        n++;
        start4 = 0;
        while (!done4 && n < 30) begin
            tick();
            n++;
        end
        check("w4_b2b_gap", 32'(n), 32'd6);
        check("w4_b2b_product", 32'(product4), 32'd15);
        tick();
        run4(4'h8, 4'd7, 1'b1, 8'hC8);
        run4(4'h8, 4'h8, 1'b1, 8'h40);

        en_cmp = 0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
